// File: rtl/fir_out_buffer.sv
// Output buffer behind fir_filter: optional 1-of-DEC decimation feeding a FWFT FIFO
// with a VOUT/READY handshake and overflow flagging. Optional macro: FIR_BUF_DROP_CNT_EN.
module fir_out_buffer #(
  parameter int NB    = 13,
  parameter int DEPTH = 8,
  parameter int AW    = 3,
  parameter int DEC   = 1
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic [NB-1:0] DIN,
  input  logic          VIN,
  output logic [NB-1:0] DOUT,
  output logic          VOUT,
  input  logic          READY,
  output logic          FULL,
  output logic          EMPTY,
  output logic [AW:0]   COUNT,
  output logic          OVF,
  output logic [7:0]    DROP_CNT
);

  logic [3:0]    r_ph;
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW:0]   r_count;
  logic          r_ovf;
  logic [NB-1:0] r_mem [DEPTH];

  logic w_full;
  logic w_empty;
  logic w_kept;
  logic w_pop;
  logic w_push;
  logic w_drop;

  always_comb begin
    w_full  = (r_count == (AW+1)'(DEPTH));
    w_empty = (r_count == '0);
    w_kept  = VIN && (r_ph == '0);
    w_pop   = !w_empty && READY;
    w_push  = w_kept && (!w_full || w_pop);
    w_drop  = w_kept && w_full && !w_pop;
  end

  // Phase advances on every valid input, kept or not.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_ph <= '0;
    end else if (VIN) begin
      if (r_ph == 4'(DEC - 1)) r_ph <= '0;
      else                     r_ph <= r_ph + 4'd1;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_ovf    <= 1'b0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      if (w_push && !w_pop)      r_count <= r_count + 1'b1;
      else if (w_pop && !w_push) r_count <= r_count - 1'b1;
      if (w_drop) r_ovf <= 1'b1;
    end
  end

  always_ff @(posedge CLK) begin
    if (w_push) r_mem[r_wr_ptr] <= DIN;
  end

`ifdef FIR_BUF_DROP_CNT_EN
  logic [7:0] r_drop_cnt;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST)                              r_drop_cnt <= '0;
    else if (w_drop && r_drop_cnt != '1)  r_drop_cnt <= r_drop_cnt + 8'd1;
  end

  assign DROP_CNT = r_drop_cnt;
`else
  assign DROP_CNT = '0;
`endif

  // Gate the unreset memory so DOUT reads 0 whenever nothing is buffered.
  assign DOUT  = w_empty ? '0 : r_mem[r_rd_ptr];
  assign VOUT  = !w_empty;
  assign FULL  = w_full;
  assign EMPTY = w_empty;
  assign COUNT = r_count;
  assign OVF   = r_ovf;

endmodule

// File: tb/tb_fir_out_buffer.sv
// Directed bench for fir_out_buffer: queue-based scoreboard on a DEC=1 and a DEC=4 instance.
module tb_fir_out_buffer;

  localparam int NB    = 13;
  localparam int DEPTH = 8;
  localparam int AW    = 3;

  logic          CLK = 1'b0;
  logic          RST;
  logic [NB-1:0] DIN, DIN2;
  logic          VIN, VIN2, READY, READY2;
  logic [NB-1:0] DOUT, DOUT2;
  logic          VOUT, VOUT2, FULL, FULL2, EMPTY, EMPTY2, OVF, OVF2;
  logic [AW:0]   COUNT, COUNT2;
  logic [7:0]    DROP_CNT, DROP_CNT2;

  int vectors = 0;
  int miscompares = 0;

  logic [NB-1:0] q[$];
  logic [NB-1:0] q2[$];
  logic [NB-1:0] got2[$];
  int   m_ph2;
  logic m_ovf;
  int   m_drop;

  always #5 CLK = ~CLK;

  fir_out_buffer #(.NB(NB), .DEPTH(DEPTH), .AW(AW), .DEC(1)) u_dut (
    .CLK(CLK), .RST(RST), .DIN(DIN), .VIN(VIN), .DOUT(DOUT), .VOUT(VOUT),
    .READY(READY), .FULL(FULL), .EMPTY(EMPTY), .COUNT(COUNT), .OVF(OVF),
    .DROP_CNT(DROP_CNT));

  fir_out_buffer #(.NB(NB), .DEPTH(DEPTH), .AW(AW), .DEC(4)) u_dec (
    .CLK(CLK), .RST(RST), .DIN(DIN2), .VIN(VIN2), .DOUT(DOUT2), .VOUT(VOUT2),
    .READY(READY2), .FULL(FULL2), .EMPTY(EMPTY2), .COUNT(COUNT2), .OVF(OVF2),
    .DROP_CNT(DROP_CNT2));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    q.delete();
    q2.delete();
    m_ph2  = 0;
    m_ovf  = 1'b0;
    m_drop = 0;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_vout"},  32'(VOUT),     32'd0);
    chk({tag, "_empty"}, 32'(EMPTY),    32'd1);
    chk({tag, "_full"},  32'(FULL),     32'd0);
    chk({tag, "_count"}, 32'(COUNT),    32'd0);
    chk({tag, "_ovf"},   32'(OVF),      32'd0);
    chk({tag, "_drop"},  32'(DROP_CNT), 32'd0);
    chk({tag, "_dout"},  32'(DOUT),     32'd0);
    chk({tag, "_vout2"}, 32'(VOUT2),    32'd0);
  endtask

  // Called 1 time unit after a rising edge; asserts RST between edges.
  task automatic async_reset(input string tag);
    #2 RST = 1'b1;
    VIN = 1'b0; VIN2 = 1'b0;
    #1 chk_reset_vals(tag);
    model_reset();
    @(posedge CLK); #1 RST = 1'b0;
  endtask

  // One clock on the DEC=1 instance; u_dec idles.
  task automatic cycle(input logic vin, input logic [NB-1:0] din, input logic ready, input string tag);
    bit pop, push;
    VIN = vin; DIN = din; READY = ready; VIN2 = 1'b0; READY2 = 1'b0;
    #1;
    chk({tag, "_count"}, 32'(COUNT), 32'(q.size()));
    chk({tag, "_vout"},  32'(VOUT),  32'(q.size() != 0));
    chk({tag, "_full"},  32'(FULL),  32'(q.size() == DEPTH));
    chk({tag, "_ovf"},   32'(OVF),   32'(m_ovf));
    chk({tag, "_drop"},  32'(DROP_CNT), 32'(m_drop));
    pop  = (q.size() != 0) && ready;
    push = vin && (q.size() < DEPTH || pop);
    if (pop) chk({tag, "_dout"}, 32'(DOUT), 32'(q.pop_front()));
    if (push) q.push_back(din);
    if (vin && !push) begin
      m_ovf = 1'b1;
`ifdef FIR_BUF_DROP_CNT_EN
      if (m_drop < 255) m_drop++;
`endif
    end
    @(posedge CLK); #1;
  endtask

  // One clock on the DEC=4 instance with READY held high.
  task automatic dcycle(input logic vin, input logic [NB-1:0] din);
    bit pop, push;
    VIN = 1'b0; READY = 1'b0; VIN2 = vin; DIN2 = din; READY2 = 1'b1;
    #1;
    chk("dec_count", 32'(COUNT2), 32'(q2.size()));
    chk("dec_vout",  32'(VOUT2),  32'(q2.size() != 0));
    pop  = (q2.size() != 0);
    push = vin && (m_ph2 == 0);
    if (pop) begin
      got2.push_back(DOUT2);
      chk("dec_dout", 32'(DOUT2), 32'(q2.pop_front()));
    end
    if (push) q2.push_back(din);
    if (vin) m_ph2 = (m_ph2 + 1) % 4;
    @(posedge CLK); #1;
  endtask

  initial begin
    logic [NB-1:0] exp_dec [4];
    RST = 1'b1; VIN = 1'b0; DIN = '0; READY = 1'b0;
    VIN2 = 1'b0; DIN2 = '0; READY2 = 1'b0;
    model_reset();
    @(posedge CLK); #1;

    // Reset held for 3 cycles with VIN toggling.
    for (int i = 0; i < 3; i++) begin
      VIN = i[0]; DIN = NB'(50 + i); VIN2 = i[0];
      #1 chk_reset_vals("rst_hold");
      @(posedge CLK); #1;
    end
    RST = 1'b0;
    cycle(1'b1, 13'd77, 1'b0, "first_after_rst");
    cycle(1'b0, 13'd0,  1'b1, "first_pop");

    // Passthrough.
    for (int i = 1; i <= 20; i++) cycle(1'b1, NB'(i), 1'b1, "pass");
    cycle(1'b0, 13'd0, 1'b1, "pass_drain");
    cycle(1'b0, 13'd0, 1'b1, "pass_idle");

    // Fill and overflow.
    for (int i = 0; i < 10; i++) cycle(1'b1, NB'(100 + i), 1'b0, "fill");
    chk("fill_full",  32'(FULL),  32'd1);
    chk("fill_count", 32'(COUNT), 32'd8);
    chk("fill_ovf",   32'(OVF),   32'd1);
`ifdef FIR_BUF_DROP_CNT_EN
    chk("fill_drop",  32'(DROP_CNT), 32'd2);
`else
    chk("fill_drop",  32'(DROP_CNT), 32'd0);
`endif
    for (int i = 0; i < 8; i++) cycle(1'b0, 13'd0, 1'b1, "drain");
    chk("drain_empty", 32'(EMPTY), 32'd1);
    chk("drain_ovf_sticky", 32'(OVF), 32'd1);

    // Full with simultaneous push/pop.
    async_reset("rst_mid1");
    for (int i = 0; i < 8; i++) cycle(1'b1, NB'(200 + i), 1'b0, "fill2");
    for (int i = 0; i < 5; i++) cycle(1'b1, NB'(300 + i), 1'b1, "pushpop");
    chk("pushpop_count", 32'(COUNT), 32'd8);
    chk("pushpop_ovf",   32'(OVF),   32'd0);
    for (int i = 0; i < 8; i++) cycle(1'b0, 13'd0, 1'b1, "drain2");

    // Decimation by 4 with VIN gaps.
    for (int i = 0; i < 16; i++) begin
      if (i % 3 == 1) dcycle(1'b0, 13'd99);
      dcycle(1'b1, NB'(i));
    end
    for (int i = 0; i < 3; i++) dcycle(1'b0, 13'd0);
    exp_dec = '{13'd0, 13'd4, 13'd8, 13'd12};
    chk("dec_num", 32'(got2.size()), 32'd4);
    for (int i = 0; i < 4 && i < got2.size(); i++) chk("dec_seq", 32'(got2[i]), 32'(exp_dec[i]));

`ifdef FIR_BUF_DROP_CNT_EN
    // Saturation of the drop counter.
    async_reset("rst_mid2");
    for (int i = 0; i < 8; i++) cycle(1'b1, NB'(i), 1'b0, "fill3");
    for (int i = 0; i < 300; i++) cycle(1'b1, NB'(i), 1'b0, "sat");
    chk("sat_drop", 32'(DROP_CNT), 32'd255);
`endif
    VIN = 1'b1;
    async_reset("rst_mid3");
    cycle(1'b1, 13'd55, 1'b0, "kept_after_rst");
    cycle(1'b0, 13'd0,  1'b1, "kept_pop");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
